// File: rtl/s_to_p_sr.sv
// Purpose     : gathers N_SLICES serial slices (LS slice first) into one wide word.
// Latency     : 1 clk from the last slice accepted to dout_vld.
// Backpressure: none; every slice with ce & din_vld is taken, ce low freezes state.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   ce           clock enable for accumulation state (strobes keep running)
//   din/din_vld  input slice and its qualifier
//   din_sync     with din_vld, forces din to be slice 0 of a new word
//   dout         assembled word, slice k at [(k+1)*SLICE_SIZE-1 : k*SLICE_SIZE]
//   dout_vld     one-cycle strobe, dout updated this cycle
//   slice_cnt    index the next accepted slice will occupy
//   sync_err     one-cycle strobe, a partial word was dropped on resync
module s_to_p_sr #(
    parameter int N_SLICES   = 4,
    parameter int SLICE_SIZE = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ce,
    input  logic [SLICE_SIZE-1:0]            din,
    input  logic                             din_vld,
    input  logic                             din_sync,
    output logic [N_SLICES*SLICE_SIZE-1:0]   dout,
    output logic                             dout_vld,
    output logic [$clog2(N_SLICES)-1:0]      slice_cnt,
    output logic                             sync_err
);

    localparam int W  = N_SLICES * SLICE_SIZE;
    localparam int CW = $clog2(N_SLICES);

    // Wrap is by compare, so non-power-of-two slice counts work.
    localparam logic [CW-1:0] LAST_IDX = CW'(N_SLICES - 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;

    logic          accept;
    logic          resync;
    logic          last;
    logic [CW-1:0] eff_idx;
    logic [W-1:0]  acc_ins;

    always_comb begin
        accept  = ce & din_vld;
        eff_idx = din_sync ? '0 : cnt;
        resync  = accept & din_sync & (cnt != '0);
        last    = (eff_idx == LAST_IDX);

        // acc is all-zero whenever cnt is 0, so clearing on every sync
        // only has a visible effect when a partial word is being dropped.
        acc_ins = din_sync ? '0 : acc;
        acc_ins[int'(eff_idx)*SLICE_SIZE +: SLICE_SIZE] = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            // Strobes are recomputed on every edge so they never stick high
            // when ce drops right after a completion or resync.
            dout_vld <= accept & last;
            sync_err <= resync;

            if (accept) begin
                if (last) begin
                    // acc_ins already carries din in the top slice.
                    dout <= acc_ins;
                    acc  <= '0;
                    cnt  <= '0;
                end else begin
                    acc  <= acc_ins;
                    cnt  <= eff_idx + CW'(1);
                end
            end
        end
    end

    assign slice_cnt = cnt;

endmodule

// File: tb/tb_s_to_p_sr.sv
module tb_s_to_p_sr;

    localparam int N = 4;
    localparam int S = 32;
    localparam int W = N * S;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [S-1:0]  din;
    logic          din_vld;
    logic          din_sync;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic [1:0]    slice_cnt;
    logic          sync_err;

    int errors = 0;
    int checks = 0;
    int vld_pulses = 0;
    int cyc = 0;
    logic [W-1:0] sb[$];
    int vld_cyc[$];

    s_to_p_sr #(.N_SLICES(N), .SLICE_SIZE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .din       (din),
        .din_vld   (din_vld),
        .din_sync  (din_sync),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .slice_cnt (slice_cnt),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every completed word is popped and compared.
    always @(negedge clk) begin
        if (!rst && dout_vld) begin
            vld_pulses++;
            vld_cyc.push_back(cyc);
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=%h expected=<none>", dout);
            end
            if (sb.size() > 0) chk("sb_word", dout, sb.pop_front());
        end
    end

    // Apply inputs, take one rising edge, return 1 time unit after it.
    task automatic step(input logic c, input logic v, input logic s, input logic [S-1:0] d);
        ce = c; din_vld = v; din_sync = s; din = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] word4(input logic [S-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    initial begin
        logic [S-1:0] t;
        rst = 1'b1; ce = 1'b0; din = '0; din_vld = 1'b0; din_sync = 1'b0;
        #12;
        chk("rst_dout", dout, '0);
        chk("rst_dout_vld", W'(dout_vld), '0);
        chk("rst_slice_cnt", W'(slice_cnt), '0);
        chk("rst_sync_err", W'(sync_err), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: four slices, LS first
        sb.push_back(128'h44444444_33333333_22222222_11111111);
        for (int k = 0; k < 4; k++) begin
            chk("t1_cnt_seq", W'(slice_cnt), W'(k));
            t = 32'h11111111 * (k + 1);
            step(1, 1, 0, t);
        end
        chk("t1_vld", W'(dout_vld), 1);
        chk("t1_cnt_wrap", W'(slice_cnt), 0);
        chk("t1_dout", dout, 128'h44444444_33333333_22222222_11111111);
        step(1, 0, 0, 32'hDEADBEEF);
        chk("t1_vld_drop", W'(dout_vld), 0);
        chk("t1_dout_hold", dout, 128'h44444444_33333333_22222222_11111111);

        // 2: eight slices back to back
        sb.push_back(word4(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003));
        sb.push_back(word4(32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007));
        vld_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            t = 32'hA000_0000 + 32'(k);
            step(1, 1, 0, t);
            if (k >= 4 && k < 7)
                chk("t2_dout_hold", dout,
                    word4(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003));
        end
        chk("t2_dout2", dout, word4(32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007));
        step(1, 0, 0, '0);
        chk("t2_pulses", W'(vld_cyc.size()), 2);
        if (vld_cyc.size() == 2)
            chk("t2_spacing", W'(vld_cyc[1] - vld_cyc[0]), 4);

        // 3: resync mid-word drops 0xA/0xB
        sb.push_back(128'h0000000F_0000000E_0000000D_0000000C);
        step(1, 1, 0, 32'hA);
        step(1, 1, 0, 32'hB);
        chk("t3_no_err_yet", W'(sync_err), 0);
        step(1, 1, 1, 32'hC);
        chk("t3_sync_err", W'(sync_err), 1);
        chk("t3_cnt_after_sync", W'(slice_cnt), 1);
        step(1, 1, 0, 32'hD);
        chk("t3_sync_err_drop", W'(sync_err), 0);
        step(1, 1, 0, 32'hE);
        step(1, 1, 0, 32'hF);
        chk("t3_vld", W'(dout_vld), 1);
        chk("t3_dout", dout, 128'h0000000F_0000000E_0000000D_0000000C);

        // 4: ce low for five cycles after two slices
        sb.push_back(word4(32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003));
        step(1, 1, 0, 32'h5000_0000);
        step(1, 1, 0, 32'h5000_0001);
        for (int k = 0; k < 5; k++) begin
            t = 32'hBAD0_0000 + 32'(k);
            step(0, 1, (k == 2), t);
            chk("t4_cnt_frozen", W'(slice_cnt), 2);
            chk("t4_no_err", W'(sync_err), 0);
        end
        chk("t4_dout_frozen", dout, 128'h0000000F_0000000E_0000000D_0000000C);
        step(1, 1, 0, 32'h5000_0002);
        step(1, 1, 0, 32'h5000_0003);
        chk("t4_vld", W'(dout_vld), 1);
        step(0, 1, 0, 32'hBAD1_0000);
        chk("t4_vld_drop_ce_low", W'(dout_vld), 0);
        chk("t4_cnt_ce_low", W'(slice_cnt), 0);

        // 5: async reset between edges after three slices
        step(1, 1, 0, 32'h7000_0000);
        step(1, 1, 0, 32'h7000_0001);
        step(1, 1, 0, 32'h7000_0002);
        ce = 1'b0; din_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_dout", dout, '0);
        chk("t5_async_cnt", W'(slice_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(word4(32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003));
        for (int k = 0; k < 4; k++) begin
            t = 32'h8000_0000 + 32'(k);
            step(1, 1, 0, t);
        end
        chk("t5_clean_word", dout, word4(32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003));

        // 6: gapped input, sync on slice 0 with cnt already 0
        sb.push_back(word4(32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003));
        for (int k = 0; k < 4; k++) begin
            t = 32'h9000_0000 + 32'(k);
            step(1, 1, (k == 0), t);
            chk("t6_no_err", W'(sync_err), 0);
            chk("t6_vld_on_last", W'(dout_vld), W'(k == 3));
            step(1, 0, 1, 32'hFFFF_FFFF);
            chk("t6_gap_no_vld", W'(dout_vld), 0);
            chk("t6_gap_no_err", W'(sync_err), 0);
        end
        chk("t6_dout", dout, word4(32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003));

        step(1, 0, 0, '0);
        chk("sb_drained", W'(sb.size()), 0);
        chk("total_pulses", W'(vld_pulses), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
